// File: rtl/hs_pkg.sv
// Shared types and constants for the handshake checking sink.
package hs_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } hs_state_e;

    typedef enum logic [1:0] {
        MODE_ALWAYS = 2'd0,
        MODE_ALT    = 2'd1,
        MODE_LFSR   = 2'd2,
        MODE_BURST  = 2'd3
    } hs_mode_e;

    // x^8 + x^6 + x^5 + x^4 + 1 -> state bits 7,5,4,3
    localparam logic [7:0] LFSR_TAPS     = 8'hB8;
    localparam logic [7:0] LFSR_SEED_DEF = 8'hA5;

    function automatic logic [7:0] lfsr_step(input logic [7:0] cur);
        return {cur[6:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/hs_ready_pattern.sv
// Backpressure pattern source: the value for the upcoming cycle, advanced once per step.
module hs_ready_pattern
    import hs_pkg::*;
#(
    parameter logic [7:0] LFSR_SEED = LFSR_SEED_DEF
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     step,
    input  hs_mode_e mode,
    output logic     pattern
);

    logic [7:0] lfsr_q;
    logic       toggle_q;
    logic [2:0] burst_q;

    // All sources advance together so a mode change never restarts a sequence.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q   <= LFSR_SEED;
            toggle_q <= 1'b0;
            burst_q  <= '0;
        end else if (step) begin
            lfsr_q   <= lfsr_step(lfsr_q);
            toggle_q <= ~toggle_q;
            burst_q  <= burst_q + 3'd1;
        end
    end

    always_comb begin
        pattern = 1'b1;
        unique case (mode)
            MODE_ALWAYS: pattern = 1'b1;
            MODE_ALT:    pattern = ~toggle_q;
            MODE_LFSR:   pattern = lfsr_q[0];
            MODE_BURST:  pattern = ~burst_q[2];
            default:     pattern = 1'b1;
        endcase
    end

endmodule

// File: rtl/handshake_check_sink.sv
// Stream sink that applies backpressure and checks incrementing data plus valid/data stability.
// state | meaning
// IDLE  | just out of reset, ready held low for one cycle
// RUN   | consuming beats, checkers active
// HALT  | stopped after an error (STOP_ON_ERR=1), left only by reset
module handshake_check_sink
    import hs_pkg::*;
#(
    parameter int                DATA_W      = 8,
    parameter logic [DATA_W-1:0] EXP_INIT    = '0,
    parameter logic [7:0]        LFSR_SEED   = LFSR_SEED_DEF,
    parameter bit                STOP_ON_ERR = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic [1:0]        mode_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              ready_o,
    output logic [15:0]       beat_cnt_o,
    output logic [7:0]        err_cnt_o,
    output logic              seq_err_o,
    output logic              proto_err_o,
    output logic              halted_o
);

    hs_state_e         state_q, state_d;
    logic [DATA_W-1:0] exp_q;
    logic [DATA_W-1:0] stall_data_q;
    logic              stall_q;
    logic              hs;
    logic              seq_err;
    logic              proto_err;
    logic              step;
    logic              pattern;
    logic [8:0]        err_sum;

    assign hs        = valid_i && ready_o;
    assign seq_err   = hs && (data_i != exp_q);
    // A stalled beat must stay valid with unchanged data on the following cycle.
    assign proto_err = (state_q == RUN) && stall_q && (!valid_i || (data_i != stall_data_q));
    assign step      = (state_d == RUN);
    assign err_sum   = {1'b0, err_cnt_o} + 9'(seq_err) + 9'(proto_err);
    assign halted_o  = (state_q == HALT);

    hs_ready_pattern #(
        .LFSR_SEED(LFSR_SEED)
    ) u_pattern (
        .clk    (clk),
        .rst    (rst),
        .step   (step),
        .mode   (hs_mode_e'(mode_i)),
        .pattern(pattern)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = RUN;
            RUN:     if (STOP_ON_ERR && (seq_err || proto_err)) state_d = HALT;
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ready_o      <= 1'b0;
            exp_q        <= EXP_INIT;
            beat_cnt_o   <= '0;
            err_cnt_o    <= '0;
            seq_err_o    <= 1'b0;
            proto_err_o  <= 1'b0;
            stall_q      <= 1'b0;
            stall_data_q <= '0;
        end else begin
            state_q      <= state_d;
            ready_o      <= step && en_i && pattern;
            stall_q      <= (state_q == RUN) && valid_i && !ready_o;
            stall_data_q <= data_i;
            if (hs) begin
                exp_q      <= data_i + DATA_W'(1);
                beat_cnt_o <= beat_cnt_o + 16'd1;
            end
            if (seq_err)   seq_err_o   <= 1'b1;
            if (proto_err) proto_err_o <= 1'b1;
            err_cnt_o <= (err_sum > 9'd255) ? 8'hFF : err_sum[7:0];
        end
    end

endmodule

// File: tb/tb_handshake_check_sink.sv
// Directed bench for handshake_check_sink; a second instance runs with STOP_ON_ERR=1.
module tb_handshake_check_sink;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic [1:0]  mode = 2'd0;
    logic        valid = 1'b0;
    logic [7:0]  data = 8'd0;

    logic        ready, seq_err, proto_err, halted;
    logic [15:0] beat_cnt;
    logic [7:0]  err_cnt;
    logic        ready_h, seq_err_h, proto_err_h, halted_h;
    logic [15:0] beat_cnt_h;
    logic [7:0]  err_cnt_h;

    int          n_tests = 0;
    int          n_fail = 0;
    int          sent_cycles;
    logic [7:0]  stim [0:299];

    always #5 clk = ~clk;

    handshake_check_sink #(.DATA_W(8), .EXP_INIT(8'd0), .LFSR_SEED(8'hA5), .STOP_ON_ERR(1'b0)) dut (
        .clk(clk), .rst(rst), .en_i(en), .mode_i(mode), .valid_i(valid), .data_i(data),
        .ready_o(ready), .beat_cnt_o(beat_cnt), .err_cnt_o(err_cnt),
        .seq_err_o(seq_err), .proto_err_o(proto_err), .halted_o(halted)
    );

    handshake_check_sink #(.DATA_W(8), .EXP_INIT(8'd0), .LFSR_SEED(8'hA5), .STOP_ON_ERR(1'b1)) dut_h (
        .clk(clk), .rst(rst), .en_i(en), .mode_i(mode), .valid_i(valid), .data_i(data),
        .ready_o(ready_h), .beat_cnt_o(beat_cnt_h), .err_cnt_o(err_cnt_h),
        .seq_err_o(seq_err_h), .proto_err_o(proto_err_h), .halted_o(halted_h)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [1:0] m);
        tick();
        rst = 1'b1; valid = 1'b0; data = 8'd0; mode = m; en = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Upstream driver: holds valid/data until each beat is accepted.
    task automatic send_beats(input int n, input int budget);
        int i = 0;
        logic rdy;
        sent_cycles = 0;
        valid = 1'b1;
        data = stim[0];
        while (i < n && sent_cycles < budget) begin
            rdy = ready;
            tick();
            sent_cycles++;
            if (rdy) begin
                i++;
                if (i < n) data = stim[i];
                else valid = 1'b0;
            end
        end
        valid = 1'b0;
        n_tests++;
        if (i !== n) begin n_fail++; $display("FAIL send_timeout: accepted %0d required %0d", i, n); end
    endtask

    task automatic test_reset();
        rst = 1'b1; valid = 1'b0; mode = 2'd0; en = 1'b1;
        tick();
        tick();
        n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %0b need 0", ready); end
        n_tests++; if (beat_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_beat: got %0d need 0", beat_cnt); end
        n_tests++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_err: got %0d need 0", err_cnt); end
        n_tests++; if ({seq_err, proto_err, halted, halted_h} !== 4'b0) begin n_fail++; $display("FAIL rst_flags: got %b need 0000", {seq_err, proto_err, halted, halted_h}); end
        rst = 1'b0;
        n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL idle_ready: got %0b need 0", ready); end
        tick();
        n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL run_ready: got %0b need 1", ready); end
    endtask

    task automatic test_always();
        do_reset(2'd0);
        tick();
        n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL m0_ready: got %0b need 1", ready); end
        for (int k = 0; k < 10; k++) stim[k] = 8'(k);
        send_beats(10, 40);
        n_tests++; if (sent_cycles !== 10) begin n_fail++; $display("FAIL m0_b2b_cycles: got %0d need 10", sent_cycles); end
        n_tests++; if (beat_cnt !== 16'd10) begin n_fail++; $display("FAIL m0_beats: got %0d need 10", beat_cnt); end
        n_tests++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL m0_err: got %0d need 0", err_cnt); end
    endtask

    task automatic test_enable();
        do_reset(2'd0);
        tick();
        en = 1'b0;
        tick();
        n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL en_low_ready: got %0b need 0", ready); end
        en = 1'b1;
        tick();
        n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL en_high_ready: got %0b need 1", ready); end
    endtask

    task automatic test_alternate();
        do_reset(2'd1);
        tick();
        for (int k = 0; k < 4; k++) stim[k] = 8'(k);
        send_beats(4, 40);
        n_tests++; if (sent_cycles !== 7) begin n_fail++; $display("FAIL m1_cycles: got %0d need 7", sent_cycles); end
        n_tests++; if (beat_cnt !== 16'd4) begin n_fail++; $display("FAIL m1_beats: got %0d need 4", beat_cnt); end
        n_tests++; if (proto_err !== 1'b0 || err_cnt !== 8'd0) begin n_fail++; $display("FAIL m1_errs: got proto=%0b cnt=%0d need 0/0", proto_err, err_cnt); end
    endtask

    task automatic test_seq_err();
        do_reset(2'd0);
        tick();
        stim[0] = 8'd0; stim[1] = 8'd1;
        send_beats(2, 20);
        n_tests++; if (seq_err !== 1'b0) begin n_fail++; $display("FAIL seq_clean: got %0b need 0", seq_err); end
        stim[0] = 8'd3;
        send_beats(1, 20);
        n_tests++; if (seq_err !== 1'b1 || err_cnt !== 8'd1) begin n_fail++; $display("FAIL seq_bad: got flag=%0b cnt=%0d need 1/1", seq_err, err_cnt); end
        stim[0] = 8'd4;
        send_beats(1, 20);
        n_tests++; if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL seq_resync: got %0d need 1", err_cnt); end
        n_tests++; if (beat_cnt !== 16'd4) begin n_fail++; $display("FAIL seq_beats: got %0d need 4", beat_cnt); end
    endtask

    task automatic test_proto_drop();
        int w = 0;
        do_reset(2'd3);
        tick();
        while (ready !== 1'b0 && w < 20) begin tick(); w++; end
        n_tests++; if (w !== 4) begin n_fail++; $display("FAIL burst_len: got %0d need 4", w); end
        valid = 1'b1; data = 8'h55;
        tick();
        n_tests++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL stall_ok: got %0b need 0", proto_err); end
        valid = 1'b0;
        tick();
        n_tests++; if (proto_err !== 1'b1 || err_cnt !== 8'd1) begin n_fail++; $display("FAIL drop: got flag=%0b cnt=%0d need 1/1", proto_err, err_cnt); end
        n_tests++; if (beat_cnt !== 16'd0 || seq_err !== 1'b0) begin n_fail++; $display("FAIL drop_side: got beats=%0d seq=%0b need 0/0", beat_cnt, seq_err); end
    endtask

    task automatic test_proto_change();
        do_reset(2'd1);
        tick();
        tick();
        n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL alt_low: got %0b need 0", ready); end
        valid = 1'b1; data = 8'd7;
        tick();
        data = 8'd8;
        tick();
        valid = 1'b0;
        n_tests++; if (err_cnt !== 8'd2) begin n_fail++; $display("FAIL dual_err_cnt: got %0d need 2", err_cnt); end
        n_tests++; if ({seq_err, proto_err} !== 2'b11) begin n_fail++; $display("FAIL dual_flags: got %b need 11", {seq_err, proto_err}); end
        n_tests++; if (beat_cnt !== 16'd1) begin n_fail++; $display("FAIL dual_beats: got %0d need 1", beat_cnt); end
    endtask

    task automatic test_halt();
        do_reset(2'd0);
        tick();
        stim[0] = 8'd0; stim[1] = 8'd1; stim[2] = 8'd5;
        send_beats(3, 20);
        n_tests++; if (halted_h !== 1'b1 || ready_h !== 1'b0) begin n_fail++; $display("FAIL halt_enter: got halted=%0b ready=%0b need 1/0", halted_h, ready_h); end
        n_tests++; if (err_cnt_h !== 8'd1 || halted !== 1'b0) begin n_fail++; $display("FAIL halt_err: got cnt=%0d nohalt=%0b need 1/0", err_cnt_h, halted); end
        valid = 1'b1; data = 8'd6;
        repeat (3) tick();
        valid = 1'b0;
        n_tests++; if (beat_cnt_h !== 16'd3 || halted_h !== 1'b1) begin n_fail++; $display("FAIL halt_hold: got beats=%0d halted=%0b need 3/1", beat_cnt_h, halted_h); end
        rst = 1'b1;
        tick();
        n_tests++; if ({halted_h, ready_h, seq_err_h, proto_err_h} !== 4'b0) begin n_fail++; $display("FAIL halt_rst_flags: got %b need 0000", {halted_h, ready_h, seq_err_h, proto_err_h}); end
        n_tests++; if (beat_cnt_h !== 16'd0 || err_cnt_h !== 8'd0) begin n_fail++; $display("FAIL halt_rst_cnt: got beats=%0d err=%0d need 0/0", beat_cnt_h, err_cnt_h); end
        rst = 1'b0;
        tick();
        n_tests++; if (ready_h !== 1'b1) begin n_fail++; $display("FAIL halt_resume: got %0b need 1", ready_h); end
    endtask

    task automatic test_lfsr();
        int i = 0;
        int cyc = 0;
        int shown = 0;
        logic rdy;
        logic [7:0] lfsr_m = 8'hA5;
        for (int k = 0; k < 300; k++) stim[k] = 8'(k % 256);
        do_reset(2'd2);
        tick();
        valid = 1'b1;
        data = stim[0];
        while (i < 300 && cyc < 2000) begin
            n_tests++;
            if (ready !== lfsr_m[0]) begin
                n_fail++;
                if (shown < 5) $display("FAIL lfsr_ready cycle %0d: got %0b need %0b", cyc, ready, lfsr_m[0]);
                shown++;
            end
            rdy = ready;
            tick();
            cyc++;
            lfsr_m = {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
            if (rdy) begin
                i++;
                if (i < 300) data = stim[i];
                else valid = 1'b0;
            end
        end
        valid = 1'b0;
        n_tests++; if (i !== 300) begin n_fail++; $display("FAIL lfsr_timeout: accepted %0d need 300", i); end
        n_tests++; if (beat_cnt !== 16'd300) begin n_fail++; $display("FAIL lfsr_beats: got %0d need 300", beat_cnt); end
        n_tests++; if (err_cnt !== 8'd0 || seq_err !== 1'b0) begin n_fail++; $display("FAIL lfsr_wrap_err: got cnt=%0d seq=%0b need 0/0", err_cnt, seq_err); end
    endtask

    initial begin
        test_reset();
        test_always();
        test_enable();
        test_alternate();
        test_seq_err();
        test_proto_drop();
        test_proto_change();
        test_halt();
        test_lfsr();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
